pll_dyn_cfg: RTL and testbench
==============================

PLL_DYN_CFG -- requirements
Module: pll_dyn_cfg

Interface
REQ-001 SHALL have parameter NUM_OUT, default 2, giving the number of output dividers driven (1..5).
REQ-002 SHALL have parameter DIV_W, default 10, giving the width of each ratio and duty field.
REQ-003 SHALL have parameter RST_CYCLES, default 16, giving the number of cycles pll_rst is held high per attempt.
REQ-004 SHALL have parameter LOCK_STABLE, default 64, giving the consecutive synced-lock cycles required to qualify lock.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65536, giving the cycles allowed per attempt for lock to qualify.
REQ-006 SHALL have parameter MAX_RETRY, default 3, giving the extra attempts after the first timeout.
REQ-007 SHALL have parameters DEF_IDIV (2), DEF_FDIV (24), DEF_ODIV (24 per channel) and DEF_DUTY (24 per channel), giving the reset-time ratios.
REQ-008 SHALL have these ports (clock and reset first); the design has one clock, and reset is synchronous and active-high:
- clkin1  in  1  controller clock (PLL reference clock)
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  new-configuration request
- cfg_ready  out  1  request accepted this cycle when cfg_valid=1
- cfg_idiv  in  DIV_W  requested input ratio
- cfg_fdiv  in  DIV_W  requested feedback ratio
- cfg_odiv  in  NUM_OUT*DIV_W  requested output ratios (channel 0 in the LSBs)
- cfg_duty  in  NUM_OUT*DIV_W  requested duty fields
- pll_lock  in  1  raw PLL lock, asynchronous
- pll_rst  out  1  PLL reset
- dyn_idiv, dyn_fdiv  out  DIV_W  applied ratios
- dyn_odiv, dyn_duty  out  NUM_OUT*DIV_W  applied ratios and duty fields
- locked  out  1  qualified lock
- busy  out  1  reconfiguration in progress
- cfg_done  out  1  one-cycle pulse on qualified lock after a sequence
- cfg_err  out  1  one-cycle pulse on rejected request or retry exhaustion
- lock_lost  out  1  one-cycle pulse when qualified lock drops

Function
REQ-009 SHALL pass pll_lock through a 2-flop synchronizer; all lock decisions SHALL use the synced value (2-cycle latency).
REQ-010 SHALL implement FSM states RST_HOLD, WAIT_LOCK, LOCKED and FAIL.
REQ-011 In RST_HOLD: pll_rst=1, busy=1, and the FSM SHALL go to WAIT_LOCK after exactly RST_CYCLES cycles.
REQ-012 In WAIT_LOCK: pll_rst=0, busy=1; the stable counter SHALL increment while synced lock=1 and clear to 0 when it is 0.
REQ-013 In WAIT_LOCK, when the stable counter reaches LOCK_STABLE, the FSM SHALL go to LOCKED and pulse cfg_done.
REQ-014 When the timeout counter reaches LOCK_TIMEOUT and retries used < MAX_RETRY, the FSM SHALL increment retries and go to RST_HOLD.
REQ-015 When the timeout counter reaches LOCK_TIMEOUT and retries are exhausted, the FSM SHALL go to FAIL and pulse cfg_err.
REQ-016 If qualification and timeout occur in the same cycle, qualification SHALL win.
REQ-017 In LOCKED: locked=1, busy=0, cfg_ready=1.
REQ-018 If synced lock drops while in LOCKED, the block SHALL pulse lock_lost, clear retries and go to RST_HOLD with the same ratios.
REQ-019 In FAIL: locked=0, busy=0, cfg_ready=1, pll_rst=0.
REQ-020 cfg_ready SHALL be 0 in RST_HOLD and WAIT_LOCK; cfg_valid in those states SHALL be ignored without error.
REQ-021 An accepted request with any ratio field equal to 0 SHALL be rejected: pulse cfg_err, leave dyn_* unchanged, and leave the state unchanged.
REQ-022 A valid accepted request SHALL load all dyn_* outputs on the next edge, clear retries, drop locked and enter RST_HOLD.
REQ-023 A valid accepted request and a lock drop in the same LOCKED cycle SHALL take the request path, with no lock_lost pulse.
REQ-024 dyn_* outputs SHALL change only on an accepted valid request or on reset.
REQ-025 Counters SHALL be $clog2-sized to their limits and SHALL saturate rather than wrap.

Reset
REQ-026 On rst=1 the block SHALL set: state RST_HOLD, pll_rst=1, dyn_* = DEF_* values, locked=0, busy=1, cfg_ready=0, cfg_done=0, cfg_err=0, lock_lost=0, all counters 0, synchronizer flops 0.
REQ-027 rst asserted mid-sequence SHALL abort the sequence and restart from the REQ-026 state; the abort SHALL produce no pulses.

Structure
REQ-028 A shared package pll_cfg_pkg SHALL hold the state enum, DIV_W, and the default ratio constants.
REQ-029 The lock synchronizer plus stable counter SHALL be one sub-module, pll_lock_qual.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2)
REQ-030 Reset release with pll_lock high -> pll_rst high for 4 cycles, then cfg_done and locked=1 10 cycles after pll_rst falls (2 sync + 8 stable).
REQ-031 pll_lock held low -> 3 pll_rst pulses, then cfg_err pulse and state FAIL after 3x(4+100) cycles; a valid request from FAIL relocks.
REQ-032 Request odiv0=40 while LOCKED -> dyn_odiv[9:0]=40 next edge, locked=0, pll_rst pulse, cfg_done after relock.
REQ-033 Request with fdiv=0 -> cfg_err pulse, dyn_* unchanged, locked stays 1.
REQ-034 pll_lock glitch low for 1 cycle in WAIT_LOCK at stable count 6 -> stable counter clears; cfg_done arrives 8 synced-high cycles later.
REQ-035 pll_lock drops while LOCKED -> lock_lost pulse, automatic RST_HOLD, relock with unchanged dyn_*.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// ============================================================================
// Module      : pll_cfg_pkg
// Description : Shared state encoding, field width and reset-time ratios
//               for the PLL dynamic reconfiguration controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_cfg_pkg;

    localparam int c_div_w    = 10;
    localparam int c_def_idiv = 2;
    localparam int c_def_fdiv = 24;
    localparam int c_def_odiv = 24;
    localparam int c_def_duty = 24;

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2,
        FAIL      = 2'd3
    } pll_state_t;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_qual.sv
// ============================================================================
// Module      : pll_lock_qual
// Description : Two-flop lock synchronizer plus saturating stable-lock counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_qual
    import pll_cfg_pkg::*;
#(
    parameter int LOCK_STABLE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    input  logic cnt_en,
    input  logic lock_async,
    output logic lock_sync,
    output logic lock_qual
);

    localparam int c_cnt_w = cnt_w(LOCK_STABLE);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(LOCK_STABLE);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LOCK_STABLE - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_stable_cnt;

    // Lock is meaningless while the PLL is held in reset, so the synchronizer
    // is flushed then and every attempt re-pays the 2-cycle sync latency.
    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= lock_async;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !cnt_en || !r_sync) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != c_cnt_max) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // Asserted in the cycle whose edge brings the count to LOCK_STABLE.
    assign lock_sync = r_sync;
    assign lock_qual = cnt_en & r_sync & (r_stable_cnt >= c_cnt_last);

endmodule

`default_nettype wire

// File: rtl/pll_dyn_cfg.sv
// ============================================================================
// Module      : pll_dyn_cfg
// Description : PLL dynamic ratio reconfiguration with reset, lock
//               qualification, timeout/retry and lock-loss recovery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_dyn_cfg
    import pll_cfg_pkg::*;
#(
    parameter int NUM_OUT      = 2,
    parameter int DIV_W        = c_div_w,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter logic [DIV_W-1:0]         DEF_IDIV = DIV_W'(c_def_idiv),
    parameter logic [DIV_W-1:0]         DEF_FDIV = DIV_W'(c_def_fdiv),
    parameter logic [NUM_OUT*DIV_W-1:0] DEF_ODIV = {NUM_OUT{DIV_W'(c_def_odiv)}},
    parameter logic [NUM_OUT*DIV_W-1:0] DEF_DUTY = {NUM_OUT{DIV_W'(c_def_duty)}}
) (
    input  logic                     clkin1,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [DIV_W-1:0]         cfg_idiv,
    input  logic [DIV_W-1:0]         cfg_fdiv,
    input  logic [NUM_OUT*DIV_W-1:0] cfg_odiv,
    input  logic [NUM_OUT*DIV_W-1:0] cfg_duty,
    input  logic                     pll_lock,
    output logic                     pll_rst,
    output logic [DIV_W-1:0]         dyn_idiv,
    output logic [DIV_W-1:0]         dyn_fdiv,
    output logic [NUM_OUT*DIV_W-1:0] dyn_odiv,
    output logic [NUM_OUT*DIV_W-1:0] dyn_duty,
    output logic                     locked,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     lock_lost
);

    localparam int c_rst_w = cnt_w(RST_CYCLES);
    localparam int c_to_w  = cnt_w(LOCK_TIMEOUT);
    localparam int c_ret_w = cnt_w(MAX_RETRY);
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_ret_w-1:0] c_ret_max  = c_ret_w'(MAX_RETRY);

    pll_state_t                 r_state;
    logic [c_rst_w-1:0]         r_rst_cnt;
    logic [c_to_w-1:0]          r_to_cnt;
    logic [c_ret_w-1:0]         r_retry;
    logic                       r_pll_rst;
    logic                       r_locked;
    logic                       r_busy;
    logic                       r_cfg_ready;
    logic                       r_cfg_done;
    logic                       r_cfg_err;
    logic                       r_lock_lost;
    logic [DIV_W-1:0]           r_dyn_idiv;
    logic [DIV_W-1:0]           r_dyn_fdiv;
    logic [NUM_OUT*DIV_W-1:0]   r_dyn_odiv;
    logic [NUM_OUT*DIV_W-1:0]   r_dyn_duty;

    logic [NUM_OUT-1:0] w_odiv_zero;
    logic               w_cfg_bad;
    logic               w_accept;
    logic               w_load;
    logic               w_in_hold;
    logic               w_in_wait;
    logic               w_lock_sync;
    logic               w_lock_qual;

    // Only divider ratios are screened; a zero duty code is left to the PLL.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_odiv_chk
            assign w_odiv_zero[gi] = (cfg_odiv[gi*DIV_W +: DIV_W] == '0);
        end
    endgenerate

    assign w_cfg_bad = (cfg_idiv == '0) | (cfg_fdiv == '0) | (|w_odiv_zero);
    assign w_accept  = cfg_valid & r_cfg_ready;
    assign w_load    = w_accept & ~w_cfg_bad;
    assign w_in_hold = (r_state == RST_HOLD);
    assign w_in_wait = (r_state == WAIT_LOCK);

    pll_lock_qual #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_qual (
        .clk        (clkin1),
        .rst        (rst),
        .sync_clr   (w_in_hold),
        .cnt_en     (w_in_wait),
        .lock_async (pll_lock),
        .lock_sync  (w_lock_sync),
        .lock_qual  (w_lock_qual)
    );

    always_ff @(posedge clkin1) begin
        if (rst) begin
            r_state     <= RST_HOLD;
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_lock_lost <= 1'b0;
            r_dyn_idiv  <= DEF_IDIV;
            r_dyn_fdiv  <= DEF_FDIV;
            r_dyn_odiv  <= DEF_ODIV;
            r_dyn_duty  <= DEF_DUTY;
        end else begin
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_lock_lost <= 1'b0;
            // A request can only be accepted in LOCKED or FAIL and always
            // takes precedence over a simultaneous lock drop.
            if (w_load) begin
                r_dyn_idiv  <= cfg_idiv;
                r_dyn_fdiv  <= cfg_fdiv;
                r_dyn_odiv  <= cfg_odiv;
                r_dyn_duty  <= cfg_duty;
                r_retry     <= '0;
                r_rst_cnt   <= '0;
                r_to_cnt    <= '0;
                r_state     <= RST_HOLD;
                r_pll_rst   <= 1'b1;
                r_locked    <= 1'b0;
                r_busy      <= 1'b1;
                r_cfg_ready <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_cfg_err <= 1'b1;
                end
                case (r_state)
                    RST_HOLD: begin
                        if (r_rst_cnt == c_rst_last) begin
                            r_state   <= WAIT_LOCK;
                            r_pll_rst <= 1'b0;
                            r_rst_cnt <= '0;
                            r_to_cnt  <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (w_lock_qual) begin
                            r_state     <= LOCKED;
                            r_locked    <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                            r_cfg_done  <= 1'b1;
                        end else if (r_to_cnt == c_to_last) begin
                            r_to_cnt <= '0;
                            if (r_retry < c_ret_max) begin
                                r_retry   <= r_retry + 1'b1;
                                r_state   <= RST_HOLD;
                                r_pll_rst <= 1'b1;
                                r_rst_cnt <= '0;
                            end else begin
                                r_state     <= FAIL;
                                r_busy      <= 1'b0;
                                r_cfg_ready <= 1'b1;
                                r_cfg_err   <= 1'b1;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!w_lock_sync) begin
                            r_lock_lost <= 1'b1;
                            r_retry     <= '0;
                            r_rst_cnt   <= '0;
                            r_to_cnt    <= '0;
                            r_state     <= RST_HOLD;
                            r_pll_rst   <= 1'b1;
                            r_locked    <= 1'b0;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
                        end
                    end
                    FAIL: begin
                        r_pll_rst <= 1'b0;
                    end
                    default: begin
                        r_state <= RST_HOLD;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign pll_rst   = r_pll_rst;
    assign dyn_idiv  = r_dyn_idiv;
    assign dyn_fdiv  = r_dyn_fdiv;
    assign dyn_odiv  = r_dyn_odiv;
    assign dyn_duty  = r_dyn_duty;
    assign locked    = r_locked;
    assign busy      = r_busy;
    assign cfg_done  = r_cfg_done;
    assign cfg_err   = r_cfg_err;
    assign lock_lost = r_lock_lost;

endmodule

`default_nettype wire

// File: tb/tb_pll_dyn_cfg.sv
// ============================================================================
// Module      : tb_pll_dyn_cfg
// Description : Directed self-checking bench for pll_dyn_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_dyn_cfg;

    logic        clkin1    = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        pll_lock  = 1'b1;
    logic [9:0]  cfg_idiv  = 10'd2;
    logic [9:0]  cfg_fdiv  = 10'd24;
    logic [19:0] cfg_odiv  = {10'd24, 10'd24};
    logic [19:0] cfg_duty  = {10'd24, 10'd24};

    logic        cfg_ready;
    logic        pll_rst;
    logic [9:0]  dyn_idiv;
    logic [9:0]  dyn_fdiv;
    logic [19:0] dyn_odiv;
    logic [19:0] dyn_duty;
    logic        locked;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        lock_lost;

    int n_cmp = 0;
    int n_err = 0;

    pll_dyn_cfg #(
        .NUM_OUT      (2),
        .DIV_W        (10),
        .RST_CYCLES   (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (100),
        .MAX_RETRY    (2)
    ) dut (
        .clkin1    (clkin1),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idiv  (cfg_idiv),
        .cfg_fdiv  (cfg_fdiv),
        .cfg_odiv  (cfg_odiv),
        .cfg_duty  (cfg_duty),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .dyn_idiv  (dyn_idiv),
        .dyn_fdiv  (dyn_fdiv),
        .dyn_odiv  (dyn_odiv),
        .dyn_duty  (dyn_duty),
        .locked    (locked),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .lock_lost (lock_lost)
    );

    always #5 clkin1 = ~clkin1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin1);
        #1;
    endtask

    task automatic set_req(input logic [9:0] idiv, input logic [9:0] fdiv,
                           input logic [9:0] odiv0, input logic [9:0] odiv1);
        cfg_idiv = idiv;
        cfg_fdiv = fdiv;
        cfg_odiv = {odiv1, odiv0};
        cfg_duty = {10'd24, 10'd24};
    endtask

    // Call just after the edge that entered RST_HOLD with pll_lock held high:
    // 4 reset cycles, then 2 sync + 8 stable cycles until qualified lock.
    task automatic lock_seq(input string tag);
        step(3);
        chk_val({tag, "_pll_rst_hold"}, 32'(pll_rst), 32'd1);
        step(1);
        chk_val({tag, "_pll_rst_fall"}, 32'(pll_rst), 32'd0);
        chk_val({tag, "_busy_wait"}, 32'(busy), 32'd1);
        step(9);
        chk_val({tag, "_locked_early"}, 32'(locked), 32'd0);
        chk_val({tag, "_done_early"}, 32'(cfg_done), 32'd0);
        step(1);
        chk_val({tag, "_locked"}, 32'(locked), 32'd1);
        chk_val({tag, "_done"}, 32'(cfg_done), 32'd1);
        chk_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk_val({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        step(1);
        chk_val({tag, "_done_pulse"}, 32'(cfg_done), 32'd0);
    endtask

    initial begin
        int  falls;
        int  errs;
        logic prev;

        // Reset state
        step(3);
        chk_val("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk_val("rst_busy", 32'(busy), 32'd1);
        chk_val("rst_locked", 32'(locked), 32'd0);
        chk_val("rst_ready", 32'(cfg_ready), 32'd0);
        chk_val("rst_pulses", {29'd0, cfg_done, cfg_err, lock_lost}, 32'd0);
        chk_val("rst_idiv", 32'(dyn_idiv), 32'd2);
        chk_val("rst_fdiv", 32'(dyn_fdiv), 32'd24);
        chk_val("rst_odiv", 32'(dyn_odiv), 32'(20'h06018));
        chk_val("rst_duty", 32'(dyn_duty), 32'(20'h06018));

        // Boot with lock already high
        rst = 1'b0;
        lock_seq("boot");

        // New odiv0 while locked
        set_req(10'd2, 10'd24, 10'd40, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk_val("req40_odiv", 32'(dyn_odiv), 32'(20'h06028));
        chk_val("req40_locked", 32'(locked), 32'd0);
        chk_val("req40_pll_rst", 32'(pll_rst), 32'd1);
        chk_val("req40_ready", 32'(cfg_ready), 32'd0);
        lock_seq("req40");

        // Zero feedback ratio is rejected
        set_req(10'd2, 10'd0, 10'd50, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk_val("bad_err", 32'(cfg_err), 32'd1);
        chk_val("bad_locked", 32'(locked), 32'd1);
        chk_val("bad_fdiv", 32'(dyn_fdiv), 32'd24);
        chk_val("bad_odiv", 32'(dyn_odiv), 32'(20'h06028));
        chk_val("bad_pll_rst", 32'(pll_rst), 32'd0);
        step(1);
        chk_val("bad_err_pulse", 32'(cfg_err), 32'd0);

        // Lock loss while locked
        pll_lock = 1'b0;
        step(2);
        chk_val("loss_locked_hold", 32'(locked), 32'd1);
        chk_val("loss_early", 32'(lock_lost), 32'd0);
        step(1);
        chk_val("loss_pulse", 32'(lock_lost), 32'd1);
        chk_val("loss_locked", 32'(locked), 32'd0);
        chk_val("loss_pll_rst", 32'(pll_rst), 32'd1);
        pll_lock = 1'b1;
        lock_seq("relock");
        chk_val("relock_odiv", 32'(dyn_odiv), 32'(20'h06028));

        // One-cycle glitch landing on stable count 6 restarts qualification
        set_req(10'd2, 10'd24, 10'd60, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk_val("glitch_odiv", 32'(dyn_odiv), 32'(20'h0603C));
        step(10);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(3);
        chk_val("glitch_no_lock_14", 32'(locked), 32'd0);
        step(6);
        chk_val("glitch_no_lock_20", 32'(locked), 32'd0);
        step(1);
        chk_val("glitch_locked_21", 32'(locked), 32'd1);
        chk_val("glitch_done_21", 32'(cfg_done), 32'd1);

        // Reset in the middle of a sequence
        set_req(10'd2, 10'd24, 10'd70, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        step(6);
        rst = 1'b1;
        pll_lock = 1'b0;
        step(1);
        chk_val("abort_pulses", {29'd0, cfg_done, cfg_err, lock_lost}, 32'd0);
        chk_val("abort_pll_rst", 32'(pll_rst), 32'd1);
        chk_val("abort_odiv", 32'(dyn_odiv), 32'(20'h06018));
        step(1);
        rst = 1'b0;

        // Lock never arrives: 3 attempts then FAIL; requests while busy are ignored
        set_req(10'd2, 10'd24, 10'd99, 10'd24);
        cfg_valid = 1'b1;
        falls = 0;
        errs  = 0;
        prev  = 1'b1;
        for (int i = 1; i <= 312; i++) begin
            step(1);
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (i < 312 && cfg_err) errs++;
            if (i == 50) cfg_valid = 1'b0;
        end
        chk_val("fail_rst_falls", 32'(falls), 32'd3);
        chk_val("fail_early_err", 32'(errs), 32'd0);
        chk_val("fail_err", 32'(cfg_err), 32'd1);
        chk_val("fail_busy", 32'(busy), 32'd0);
        chk_val("fail_ready", 32'(cfg_ready), 32'd1);
        chk_val("fail_pll_rst", 32'(pll_rst), 32'd0);
        chk_val("fail_odiv", 32'(dyn_odiv), 32'(20'h06018));
        step(1);
        chk_val("fail_err_pulse", 32'(cfg_err), 32'd0);
        chk_val("fail_stay", 32'(pll_rst), 32'd0);

        // Valid request from FAIL relocks
        pll_lock = 1'b1;
        set_req(10'd3, 10'd30, 10'd33, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk_val("frelock_idiv", 32'(dyn_idiv), 32'd3);
        chk_val("frelock_fdiv", 32'(dyn_fdiv), 32'd30);
        chk_val("frelock_odiv", 32'(dyn_odiv), 32'(20'h06021));
        chk_val("frelock_pll_rst", 32'(pll_rst), 32'd1);
        lock_seq("frelock");

        // Request in the same cycle the synced lock drops
        pll_lock = 1'b0;
        step(2);
        set_req(10'd3, 10'd30, 10'd44, 10'd24);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk_val("reqdrop_no_loss", 32'(lock_lost), 32'd0);
        chk_val("reqdrop_odiv", 32'(dyn_odiv), 32'(20'h0602C));
        chk_val("reqdrop_pll_rst", 32'(pll_rst), 32'd1);
        pll_lock = 1'b1;
        lock_seq("reqdrop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
